// File: rtl/vending_machine_param_if.sv
// Customer-side bus of the parametrised vending machine: coin, select,
// cancel and restock strobes in; credit, dispense and change strobes out.
interface vending_machine_param_if #(
    parameter int NUM_ITEMS = 3,
    parameter int CREDIT_W  = 8
);
    logic                 coin_valid;
    logic [1:0]           coin_sel;
    logic                 sel_valid;
    logic [2:0]           sel_idx;
    logic                 cancel;
    logic                 restock;
    logic [CREDIT_W-1:0]  credit;
    logic [NUM_ITEMS-1:0] del;
    logic [CREDIT_W-1:0]  change;
    logic                 change_valid;
    logic                 coin_reject;
    logic [NUM_ITEMS-1:0] sold_out;
    logic                 sel_error;
    logic                 busy;

    modport master (
        output coin_valid, coin_sel, sel_valid, sel_idx, cancel, restock,
        input  credit, del, change, change_valid, coin_reject, sold_out,
               sel_error, busy
    );

    modport slave (
        input  coin_valid, coin_sel, sel_valid, sel_idx, cancel, restock,
        output credit, del, change, change_valid, coin_reject, sold_out,
               sel_error, busy
    );
endinterface

// File: rtl/vending_machine_param.sv
// Multi-product cash vending controller: credit accumulator, per-item price and
// stock, one-cycle VEND/REFUND states driving registered dispense/change strobes.
module vending_machine_param #(
    parameter int                              NUM_ITEMS  = 3,
    parameter int                              CREDIT_W   = 8,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0]   PRICES     = {8'd25, 8'd20, 8'd15},
    parameter int                              MAX_CREDIT = 60,
    parameter int                              STOCK_W    = 4,
    parameter int                              INIT_STOCK = 10
) (
    input logic                    clk,
    input logic                    reset,
    vending_machine_param_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, REFUND} state_t;

    state_t               state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
    logic [2:0]           idx_q, idx_d;
    logic [CREDIT_W-1:0]  chg_amt_q, chg_amt_d;

    logic [NUM_ITEMS-1:0] del_q, del_d;
    logic [CREDIT_W-1:0]  change_q, change_d;
    logic                 change_valid_q, change_valid_d;
    logic                 coin_reject_q, coin_reject_d;
    logic [NUM_ITEMS-1:0] sold_out_q, sold_out_d;
    logic                 sel_error_q, sel_error_d;
    logic                 busy_q, busy_d;

    logic                 sel_ok;
    logic [CREDIT_W-1:0]  sel_price;
    logic [STOCK_W-1:0]   sel_stock;
    logic [CREDIT_W:0]    coin_sum;

    function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] code);
        case (code)
            2'd0:    coin_value = (CREDIT_W+1)'(5);
            2'd1:    coin_value = (CREDIT_W+1)'(10);
            2'd2:    coin_value = (CREDIT_W+1)'(20);
            default: coin_value = '0;
        endcase
    endfunction

    // One bit of headroom: the sum is compared before it is ever truncated.
    function automatic logic coin_fits(input logic [1:0] code, input logic [CREDIT_W:0] sum);
        coin_fits = (code != 2'd3) && (sum <= (CREDIT_W+1)'(MAX_CREDIT));
    endfunction

    assign coin_sum = {1'b0, credit_q} + coin_value(bus.coin_sel);

    // Looping over the table keeps out-of-range indices from ever selecting bits.
    always_comb begin
        sel_ok    = 1'b0;
        sel_price = '0;
        sel_stock = '0;
        for (int k = 0; k < NUM_ITEMS; k++) begin
            if (bus.sel_idx == 3'(k)) begin
                sel_ok    = 1'b1;
                sel_price = PRICES[k*CREDIT_W +: CREDIT_W];
                sel_stock = stock_q[k];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        idx_d          = idx_q;
        chg_amt_d      = chg_amt_q;
        for (int k = 0; k < NUM_ITEMS; k++) stock_d[k] = stock_q[k];
        del_d          = '0;
        change_d       = '0;
        change_valid_d = 1'b0;
        coin_reject_d  = 1'b0;
        sel_error_d    = 1'b0;

        case (state_q)
            VEND: begin
                for (int k = 0; k < NUM_ITEMS; k++) begin
                    if (idx_q == 3'(k)) begin
                        del_d[k]   = 1'b1;
                        stock_d[k] = stock_q[k] - STOCK_W'(1);
                    end
                end
                change_d       = chg_amt_q;
                change_valid_d = 1'b1;
                credit_d       = '0;
                coin_reject_d  = bus.coin_valid;
                state_d        = IDLE;
            end
            REFUND: begin
                change_d       = credit_q;
                change_valid_d = 1'b1;
                credit_d       = '0;
                coin_reject_d  = bus.coin_valid;
                state_d        = IDLE;
            end
            default: begin
                // Arbitration: cancel beats select beats coin; a losing coin is returned.
                if (bus.cancel) begin
                    coin_reject_d = bus.coin_valid;
                    if (credit_q != '0) state_d = REFUND;
                end else if (bus.sel_valid) begin
                    coin_reject_d = bus.coin_valid;
                    if (!sel_ok || sel_stock == '0) begin
                        sel_error_d = 1'b1;
                    end else if (credit_q >= sel_price) begin
                        idx_d     = bus.sel_idx;
                        chg_amt_d = credit_q - sel_price;
                        state_d   = VEND;
                    end
                end else if (bus.coin_valid) begin
                    if (coin_fits(bus.coin_sel, coin_sum)) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
                // The select decision above already used the pre-restock count.
                if (bus.restock) begin
                    for (int k = 0; k < NUM_ITEMS; k++) stock_d[k] = STOCK_W'(INIT_STOCK);
                end
            end
        endcase

        for (int k = 0; k < NUM_ITEMS; k++) sold_out_d[k] = (stock_d[k] == '0);
        busy_d = (state_d == VEND) || (state_d == REFUND);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            for (int k = 0; k < NUM_ITEMS; k++) stock_q[k] <= STOCK_W'(INIT_STOCK);
            idx_q          <= '0;
            chg_amt_q      <= '0;
            del_q          <= '0;
            change_q       <= '0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            sold_out_q     <= (INIT_STOCK == 0) ? '1 : '0;
            sel_error_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            for (int k = 0; k < NUM_ITEMS; k++) stock_q[k] <= stock_d[k];
            idx_q          <= idx_d;
            chg_amt_q      <= chg_amt_d;
            del_q          <= del_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            coin_reject_q  <= coin_reject_d;
            sold_out_q     <= sold_out_d;
            sel_error_q    <= sel_error_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.credit       = credit_q;
    assign bus.del          = del_q;
    assign bus.change       = change_q;
    assign bus.change_valid = change_valid_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.sold_out     = sold_out_q;
    assign bus.sel_error    = sel_error_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: directed scenarios with literal expectations,
// then random traffic checked every cycle against a transaction-level model.
module tb_vending_machine_param;
    localparam int N = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vending_machine_param_if #(.NUM_ITEMS(N), .CREDIT_W(8)) bus ();

    vending_machine_param #(
        .NUM_ITEMS(N), .CREDIT_W(8), .PRICES({8'd25, 8'd20, 8'd15}),
        .MAX_CREDIT(60), .STOCK_W(4), .INIT_STOCK(10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int price [N] = '{15, 20, 25};
    int m_credit;
    int m_stock [N];
    int m_pend;          // 0 none, 1 dispense owed, 2 refund owed
    int m_pidx;
    int m_pamt;
    int e_del, e_chg, e_cv, e_rej, e_serr;
    bit check_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sold_mask();
        int m = 0;
        for (int i = 0; i < N; i++) if (m_stock[i] == 0) m |= (1 << i);
        return m;
    endfunction

    // Model: what the customer sees after the edge that sampled the current inputs.
    function automatic void model_update();
        int v;
        int si;
        e_del = 0; e_chg = 0; e_cv = 0; e_rej = 0; e_serr = 0;
        si = int'(bus.sel_idx);
        if (reset) begin
            m_credit = 0;
            m_pend = 0;
            for (int i = 0; i < N; i++) m_stock[i] = 10;
        end else if (m_pend == 1) begin
            e_del = 1 << m_pidx;
            e_chg = m_pamt;
            e_cv = 1;
            m_stock[m_pidx] -= 1;
            m_credit = 0;
            m_pend = 0;
            e_rej = int'(bus.coin_valid);
        end else if (m_pend == 2) begin
            e_chg = m_credit;
            e_cv = 1;
            m_credit = 0;
            m_pend = 0;
            e_rej = int'(bus.coin_valid);
        end else begin
            if (bus.cancel) begin
                e_rej = int'(bus.coin_valid);
                if (m_credit > 0) m_pend = 2;
            end else if (bus.sel_valid) begin
                e_rej = int'(bus.coin_valid);
                if (si >= N) e_serr = 1;
                else if (m_stock[si] == 0) e_serr = 1;
                else if (m_credit >= price[si]) begin
                    m_pend = 1;
                    m_pidx = si;
                    m_pamt = m_credit - price[si];
                end
            end else if (bus.coin_valid) begin
                case (int'(bus.coin_sel))
                    0: v = 5;
                    1: v = 10;
                    2: v = 20;
                    default: v = -1;
                endcase
                if (v < 0 || m_credit + v > 60) e_rej = 1;
                else m_credit += v;
            end
            if (bus.restock) for (int i = 0; i < N; i++) m_stock[i] = 10;
        end
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            chk("credit", int'(bus.credit), m_credit);
            chk("del", int'(bus.del), e_del);
            chk("change_valid", int'(bus.change_valid), e_cv);
            if (e_cv != 0) chk("change", int'(bus.change), e_chg);
            chk("coin_reject", int'(bus.coin_reject), e_rej);
            chk("sel_error", int'(bus.sel_error), e_serr);
            chk("sold_out", int'(bus.sold_out), sold_mask());
            chk("busy", int'(bus.busy), int'(m_pend != 0));
        end
    end

    task automatic idle_inputs();
        bus.coin_valid = 1'b0; bus.coin_sel = 2'd0;
        bus.sel_valid = 1'b0;  bus.sel_idx = 3'd0;
        bus.cancel = 1'b0;     bus.restock = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_update();
        idle_inputs();
    endtask

    task automatic coin(input int cs);
        bus.coin_valid = 1'b1; bus.coin_sel = 2'(cs);
        tick();
    endtask

    task automatic sel(input int i);
        bus.sel_valid = 1'b1; bus.sel_idx = 3'(i);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        check_en = 1'b1;
        chk("rst_credit", int'(bus.credit), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_sold_out", int'(bus.sold_out), 0);
        chk("rst_change_valid", int'(bus.change_valid), 0);
        reset = 1'b0;

        // Coin 10 + 5, buy item 0 at exact price.
        coin(1);
        chk("t1_credit10", int'(bus.credit), 10);
        coin(0);
        chk("t1_credit15", int'(bus.credit), 15);
        sel(0);
        chk("t1_busy", int'(bus.busy), 1);
        tick();
        chk("t1_del", int'(bus.del), 1);
        chk("t1_change", int'(bus.change), 0);
        chk("t1_cv", int'(bus.change_valid), 1);
        chk("t1_credit0", int'(bus.credit), 0);

        // 40 in, item 1 costs 20, change 20.
        coin(2); coin(2);
        sel(1);
        tick();
        chk("t2_del", int'(bus.del), 2);
        chk("t2_change", int'(bus.change), 20);

        // Credit ceiling, then refund of 60.
        coin(2); coin(2); coin(2);
        chk("t3_credit60", int'(bus.credit), 60);
        coin(2);
        chk("t3_reject", int'(bus.coin_reject), 1);
        chk("t3_credit_kept", int'(bus.credit), 60);
        bus.cancel = 1'b1;
        tick();
        tick();
        chk("t3_refund", int'(bus.change), 60);
        chk("t3_refund_cv", int'(bus.change_valid), 1);
        chk("t3_credit0", int'(bus.credit), 0);

        // Drain item 2, then try again, then restock.
        for (int k = 0; k < 10; k++) begin
            coin(2); coin(0); sel(2); tick();
        end
        chk("t4_sold_out", int'(bus.sold_out), 4);
        coin(2); coin(0); sel(2);
        chk("t4_sel_error", int'(bus.sel_error), 1);
        chk("t4_credit_kept", int'(bus.credit), 25);
        bus.restock = 1'b1;
        tick();
        chk("t4_restocked", int'(bus.sold_out), 0);

        // cancel + select + coin together with 25 credit.
        bus.cancel = 1'b1; bus.sel_valid = 1'b1; bus.sel_idx = 3'd0;
        bus.coin_valid = 1'b1; bus.coin_sel = 2'd0;
        tick();
        chk("t5_reject", int'(bus.coin_reject), 1);
        tick();
        chk("t5_change", int'(bus.change), 25);
        chk("t5_cv", int'(bus.change_valid), 1);
        chk("t5_no_del", int'(bus.del), 0);

        // Reset during the VEND cycle aborts the dispense.
        coin(1); coin(0); sel(0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_no_del", int'(bus.del), 0);
        chk("t6_no_cv", int'(bus.change_valid), 0);
        chk("t6_credit0", int'(bus.credit), 0);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            bus.coin_valid = ($urandom_range(0, 2) == 0);
            bus.coin_sel   = 2'($urandom_range(0, 3));
            bus.sel_valid  = ($urandom_range(0, 5) == 0);
            bus.sel_idx    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
                                                         : 3'($urandom_range(0, 2));
            bus.cancel     = ($urandom_range(0, 19) == 0);
            bus.restock    = ($urandom_range(0, 399) == 0);
            reset          = ($urandom_range(0, 999) == 0);
            tick();
            reset = 1'b0;
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
- Parametrised successor to the single-product cash vending FSM.
- Holds a credit accumulator fed by 5/10/20 coins and serves NUM_ITEMS products, each with its own price and stock counter.
- Dispenses one item per vend with exact change; refunds all credit on cancel.
- Sits between the coin-acceptor front end and the dispenser and change-hopper drivers.

Parameters:
- NUM_ITEMS, 3, number of products (1..8).
- CREDIT_W, 8, width of credit, price and change values.
- PRICES, {8'd25,8'd20,8'd15}, packed NUM_ITEMS×CREDIT_W price table; item i is at bits [i*CREDIT_W +: CREDIT_W].
- MAX_CREDIT, 60, credit ceiling; a coin that would exceed it is rejected.
- STOCK_W, 4, stock counter width.
- INIT_STOCK, 10, stock loaded at reset and on restock.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- coin_valid  in  1  one-cycle coin strobe.
- coin_sel  in  2  coin value code: 0=5, 1=10, 2=20, 3=invalid.
- sel_valid  in  1  one-cycle product-select strobe.
- sel_idx  in  3  selected item index.
- cancel  in  1  one-cycle refund request.
- restock  in  1  one-cycle reload of all stock counters.
- credit  out  CREDIT_W  current accumulated credit.
- del  out  NUM_ITEMS  one-hot dispense pulse.
- change  out  CREDIT_W  change amount; valid only with change_valid.
- change_valid  out  1  one-cycle change strobe.
- coin_reject  out  1  one-cycle pulse: coin returned to customer.
- sold_out  out  NUM_ITEMS  bit i high while stock[i]==0.
- sel_error  out  1  one-cycle pulse: bad index or sold-out item.
- busy  out  1  high in VEND or REFUND.

Behaviour:
- Reset, sampled at posedge clk:
  - state=IDLE, credit=0, stock[i]=INIT_STOCK for every i.
  - del, change, change_valid, coin_reject, sel_error and busy all 0.
  - sold_out=0, assuming INIT_STOCK>0.
- Reset overrides every other input and aborts a VEND or REFUND in progress. An aborted vend produces no del and no change pulse.
- States: IDLE (credit==0), CREDIT (credit>0), VEND, REFUND.
- Input priority within one cycle, IDLE/CREDIT only: cancel > sel_valid > coin_valid.
  - A coin strobe that loses arbitration, or arrives in VEND/REFUND, is not credited and raises coin_reject the next cycle.
  - A sel_valid arriving in VEND/REFUND is ignored.
- Coin acceptance:
  - Value v is decoded from coin_sel.
  - coin_sel==3 or credit+v > MAX_CREDIT: coin_reject pulses the next cycle and credit is unchanged.
  - Otherwise credit <= credit+v. Credit is visible the cycle after the strobe, then state=CREDIT.
  - credit+v is computed at CREDIT_W+1 bits so no overflow can occur.
- Selection, evaluated in the cycle sel_valid is sampled:
  - sel_idx >= NUM_ITEMS, or stock[sel_idx]==0: sel_error pulses the next cycle; state and credit are unchanged.
  - credit < PRICES[sel_idx]: ignored, no pulse.
  - Otherwise latch idx, latch change_amt = credit − price, and go to VEND.
- VEND, exactly one cycle (first cycle after the select):
  - del[idx]=1, change=change_amt, change_valid=1 (also when change_amt==0).
  - stock[idx] decrements, credit <= 0; next state IDLE.
  - End-to-end latency: select at edge N, outputs at edge N+1.
- Cancel:
  - credit==0: no-op, no change_valid.
  - Otherwise go to REFUND. That cycle drives change=credit and change_valid=1, then credit <= 0; next state IDLE.
- restock:
  - Honoured only in IDLE/CREDIT. Sets every stock[i]=INIT_STOCK the next cycle.
  - Ignored in VEND/REFUND.
  - If it coincides with a selection, the vend decision uses the pre-restock stock value.
- Stock never wraps: a decrement at 0 cannot occur because the sold-out check blocks it.
- All outputs are registered.
- del and change_valid are never high in the same cycle as a REFUND.

Test Plan:
- Reset, then coin 10, coin 5, select item 0 (price 15) → credit 10 then 15; next cycle del=3'b001, change=0, change_valid=1, stock[0]=9, credit=0.
- Coins 20+20, select item 1 (price 20) → del=3'b010, change=20, change_valid=1.
- Credit 20, then 20, then 20 (total 60), then another 20 → fourth coin gives coin_reject=1, credit stays 60; cancel → change=60, change_valid=1, credit=0.
- Vend item 2 ten times → sold_out[2]=1; further select of item 2 → sel_error=1, no del, credit retained; restock → sold_out[2]=0.
- cancel, sel_valid and coin_valid asserted in the same cycle with credit 25 → REFUND change=25, coin_reject=1, no del.
- reset asserted in the VEND cycle → no del, no change_valid, credit=0, stock restored to 10.
